serial_rx_param: RTL and testbench
==================================

// Module: serial_rx_param
// PURPOSE
//   Parametrised serial byte receiver: one bit per clk, LSB first, optional parity bit, 1 or 2 stop bits.
//   Generalises the fixed 8-bit odd-parity receiver (width, parity mode, stop count) and adds error flags.
//   Sits after the line synchroniser; feeds the byte-assembly / FIFO stage.
// PARAMETERS
//   DATA_W       8   data bits per frame, legal range 5..16
//   PARITY_MODE  1   0 = no parity bit, 1 = odd (data + parity has an odd count of 1s), 2 = even
//   STOP_BITS    1   stop bits per frame (1 or 2), each must be 1
// PORTS
//   clk        in   1       clock, all logic on posedge
//   reset      in   1       synchronous, active-high
//   in         in   1       serial line, idle = 1, one bit sampled per clk
//   out_byte   out  DATA_W  last accepted data word, valid while done = 1
//   done       out  1       1-cycle pulse: frame accepted (stop OK and parity OK)
//   parity_err out  1       1-cycle pulse: stop OK but parity failed, word discarded
//   frame_err  out  1       1-cycle pulse: a stop bit sampled as 0
//   busy       out  1       1 from start-bit sample until frame end (DATA/PARITY/STOP states)
// BEHAVIOUR
//   Reset: state = IDLE; out_byte = 0; done, parity_err, frame_err, busy = 0; shift reg, bit cnt, parity reg cleared.
//   States: IDLE, DATA, PARITY, STOP1, STOP2, DONE, BAD, WAIT.
//   IDLE: in = 0 is the start bit -> DATA, clear bit cnt and parity reg. Otherwise stay.
//   DATA: shift in into MSB of DATA_W shift reg (right shift, LSB first); toggle parity reg on in = 1;
//     after DATA_W samples -> PARITY if PARITY_MODE != 0, else STOP1.
//   PARITY: toggle parity reg on in = 1 -> STOP1. OK when reg = 1 (odd) or reg = 0 (even).
//   STOP1: in = 1 -> STOP2 if STOP_BITS = 2, else DONE or BAD by parity result. in = 0 -> WAIT.
//   STOP2: same rule as STOP1 (in = 1 -> DONE/BAD, in = 0 -> WAIT).
//   DONE (done = 1, out_byte loaded on entry): in = 0 is a new start bit -> DATA (back-to-back); else -> IDLE.
//   BAD (parity_err = 1, out_byte unchanged): same exits as DONE.
//   WAIT (frame_err = 1 on entry cycle only): stay while in = 0; in = 1 -> IDLE. No start detection in WAIT.
//   Latency: done/parity_err/frame_err assert in the cycle after the deciding bit is sampled.
//   done, parity_err and frame_err are mutually exclusive registered Moore outputs.
//   out_byte holds its value between frames; only DONE entry updates it.
//   Reset mid-frame: partial word discarded; IDLE next cycle; out_byte returns to 0.
//   Bit counter width $clog2(DATA_W+1); no wrap, because it is cleared on every start bit.
// CONFIGURATION
//   SERIAL_RX_ERR_CNT_EN defined: adds ports par_err_cnt[7:0] and frm_err_cnt[7:0] (out).
//     Each counter increments on its error pulse and saturates at 8'hFF. Cleared only by reset.
//   Not defined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//   T1 defaults: in = 0, data 0xD2 LSB first (0,1,0,0,1,0,1,1), parity 1, stop 1 -> next cycle done = 1, out_byte = 8'hD2.
//   T2 defaults: same frame with parity 0 -> parity_err = 1 for 1 cycle, done = 0, out_byte keeps its prior value.
//   T3 defaults: valid 0x5A frame with stop = 0, line held 0 for 3 cycles, then 1 -> frame_err pulses once;
//     IDLE after the 1; a following 0x3C frame gives done = 1, out_byte = 8'h3C.
//   T4 defaults: two frames 0x01, 0x80 with start bit directly after stop (no idle) -> two done pulses 11 cycles apart.
//   T5 DATA_W = 7, PARITY_MODE = 0, STOP_BITS = 2: frame 0x41 + stop 1, 1 -> done = 1 at cycle 10, out_byte = 7'h41;
//     second stop bit = 0 -> frame_err = 1.
//   T6 reset asserted mid-DATA (bit 4) -> IDLE next cycle, out_byte = 0, no pulses; next valid frame is received normally.
//     With SERIAL_RX_ERR_CNT_EN: 300 parity errors -> par_err_cnt = 8'hFF.

Source files
------------

// File: rtl/serial_rx_param.sv
// Parametrised LSB-first serial receiver: start bit, DATA_W data bits, optional parity, 1-2 stop bits.
// Define SERIAL_RX_ERR_CNT_EN to add saturating parity/framing error counters.
module serial_rx_param #(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  output logic [DATA_W-1:0] out_byte,
  output logic              done,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
`ifdef SERIAL_RX_ERR_CNT_EN
  ,
  output logic [7:0]        par_err_cnt,
  output logic [7:0]        frm_err_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_DONE,
    S_BAD,
    S_WAIT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_par;
  logic [DATA_W-1:0]   r_out;
  logic                r_done;
  logic                r_perr;
  logic                r_ferr;
  logic                r_busy;
  logic                w_last_data;
  logic                w_par_ok;
  logic                w_start;

  assign w_last_data = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_par_ok    = (PARITY_MODE == 0) ? 1'b1 :
                       (PARITY_MODE == 1) ? r_par : ~r_par;
  // DONE and BAD behave like IDLE for start detection, giving back-to-back frames
  assign w_start     = ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_BAD)) && !in;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!in) w_next = S_DATA;
      S_DATA:   if (w_last_data) w_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP1;
      S_PARITY: w_next = S_STOP1;
      S_STOP1: begin
        if (!in)                 w_next = S_WAIT;
        else if (STOP_BITS == 2) w_next = S_STOP2;
        else                     w_next = w_par_ok ? S_DONE : S_BAD;
      end
      S_STOP2: begin
        if (!in) w_next = S_WAIT;
        else     w_next = w_par_ok ? S_DONE : S_BAD;
      end
      S_DONE,
      S_BAD:    w_next = in ? S_IDLE : S_DATA;
      S_WAIT:   if (in) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cnt <= '0;
        r_par <= 1'b0;
      end
      if (r_state == S_DATA) begin
        r_shift <= {in, r_shift[DATA_W-1:1]};
        r_cnt   <= r_cnt + CNT_W'(1);
        r_par   <= r_par ^ in;
      end
      if (r_state == S_PARITY) r_par <= r_par ^ in;
      if (w_next == S_DONE) r_out <= r_shift;
      r_done <= (w_next == S_DONE);
      r_perr <= (w_next == S_BAD);
      r_ferr <= (w_next == S_WAIT) && (r_state != S_WAIT);
      r_busy <= (w_next == S_DATA) || (w_next == S_PARITY) ||
                (w_next == S_STOP1) || (w_next == S_STOP2);
    end
  end

  assign out_byte   = r_out;
  assign done       = r_done;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;

`ifdef SERIAL_RX_ERR_CNT_EN
  logic [7:0] r_pcnt;
  logic [7:0] r_fcnt;

  // Counters step together with the pulse they count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt <= '0;
      r_fcnt <= '0;
    end else begin
      if ((w_next == S_BAD) && (r_pcnt != 8'hFF)) r_pcnt <= r_pcnt + 8'd1;
      if ((w_next == S_WAIT) && (r_state != S_WAIT) && (r_fcnt != 8'hFF)) r_fcnt <= r_fcnt + 8'd1;
    end
  end

  assign par_err_cnt = r_pcnt;
  assign frm_err_cnt = r_fcnt;
`endif

endmodule

// File: tb/tb_serial_rx_param.sv
// Bench for serial_rx_param: three configurations checked every cycle against a frame-level model,
// plus directed frames with literal expectations.
module tb_serial_rx_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line [3];
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [7:0]  a_out;
  logic [6:0]  b_out;
  logic [15:0] c_out;
  logic        act_done [3];
  logic        act_perr [3];
  logic        act_ferr [3];
  logic        act_busy [3];
  logic [15:0] act_out  [3];
`ifdef SERIAL_RX_ERR_CNT_EN
  logic [7:0]  act_pc [3];
  logic [7:0]  act_fc [3];
`endif

  serial_rx_param #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(rst), .in(line[0]), .out_byte(a_out), .done(act_done[0]),
    .parity_err(act_perr[0]), .frame_err(act_ferr[0]), .busy(act_busy[0])
`ifdef SERIAL_RX_ERR_CNT_EN
    , .par_err_cnt(act_pc[0]), .frm_err_cnt(act_fc[0])
`endif
  );
  serial_rx_param #(.DATA_W(7), .PARITY_MODE(0), .STOP_BITS(2)) u_b (
    .clk(clk), .reset(rst), .in(line[1]), .out_byte(b_out), .done(act_done[1]),
    .parity_err(act_perr[1]), .frame_err(act_ferr[1]), .busy(act_busy[1])
`ifdef SERIAL_RX_ERR_CNT_EN
    , .par_err_cnt(act_pc[1]), .frm_err_cnt(act_fc[1])
`endif
  );
  serial_rx_param #(.DATA_W(16), .PARITY_MODE(2), .STOP_BITS(1)) u_c (
    .clk(clk), .reset(rst), .in(line[2]), .out_byte(c_out), .done(act_done[2]),
    .parity_err(act_perr[2]), .frame_err(act_ferr[2]), .busy(act_busy[2])
`ifdef SERIAL_RX_ERR_CNT_EN
    , .par_err_cnt(act_pc[2]), .frm_err_cnt(act_fc[2])
`endif
  );

  assign act_out[0] = {8'b0, a_out};
  assign act_out[1] = {9'b0, b_out};
  assign act_out[2] = c_out;

  int cfg_dw [3] = '{8, 7, 16};
  int cfg_pm [3] = '{1, 0, 2};
  int cfg_sb [3] = '{1, 2, 1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // phase 0: line free (start detect), 1: collecting frame bits, 2: waiting for line high
  int          m_ph   [3] = '{0, 0, 0};
  int          m_n    [3] = '{0, 0, 0};
  logic        m_bits [3][24];
  logic [15:0] e_out  [3] = '{16'h0, 16'h0, 16'h0};
  logic        e_done [3] = '{1'b0, 1'b0, 1'b0};
  logic        e_perr [3] = '{1'b0, 1'b0, 1'b0};
  logic        e_ferr [3] = '{1'b0, 1'b0, 1'b0};
  logic        e_busy [3] = '{1'b0, 1'b0, 1'b0};
  int          e_pc   [3] = '{0, 0, 0};
  int          e_fc   [3] = '{0, 0, 0};
  logic        mb;
  int          ones;
  int          plen;
  logic [15:0] word;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      mb = line[k];
      e_done[k] = 1'b0;
      e_perr[k] = 1'b0;
      e_ferr[k] = 1'b0;
      plen = cfg_dw[k] + ((cfg_pm[k] != 0) ? 1 : 0);
      if (rst) begin
        m_ph[k] = 0;
        e_out[k] = '0;
        e_pc[k] = 0;
        e_fc[k] = 0;
      end else begin
        case (m_ph[k])
          0: if (!mb) begin m_ph[k] = 1; m_n[k] = 0; end
          1: begin
            m_bits[k][m_n[k]] = mb;
            m_n[k]++;
            if (m_n[k] > plen && !mb) begin
              e_ferr[k] = 1'b1;
              if (e_fc[k] < 255) e_fc[k]++;
              m_ph[k] = 2;
            end else if (m_n[k] == plen + cfg_sb[k]) begin
              word = '0;
              ones = 0;
              for (int i = 0; i < cfg_dw[k]; i++) begin
                word[i] = m_bits[k][i];
                ones += int'(m_bits[k][i]);
              end
              if (cfg_pm[k] != 0) ones += int'(m_bits[k][cfg_dw[k]]);
              if (cfg_pm[k] == 0 || (ones % 2) == ((cfg_pm[k] == 1) ? 1 : 0)) begin
                e_done[k] = 1'b1;
                e_out[k] = word;
              end else begin
                e_perr[k] = 1'b1;
                if (e_pc[k] < 255) e_pc[k]++;
              end
              m_ph[k] = 0;
            end
          end
          default: if (mb) m_ph[k] = 0;
        endcase
      end
      e_busy[k] = (m_ph[k] == 1);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d out_byte", k), 32'(act_out[k]), 32'(e_out[k]));
        chk($sformatf("u%0d done", k), 32'(act_done[k]), 32'(e_done[k]));
        chk($sformatf("u%0d parity_err", k), 32'(act_perr[k]), 32'(e_perr[k]));
        chk($sformatf("u%0d frame_err", k), 32'(act_ferr[k]), 32'(e_ferr[k]));
        chk($sformatf("u%0d busy", k), 32'(act_busy[k]), 32'(e_busy[k]));
`ifdef SERIAL_RX_ERR_CNT_EN
        chk($sformatf("u%0d par_err_cnt", k), 32'(act_pc[k]), e_pc[k]);
        chk($sformatf("u%0d frm_err_cnt", k), 32'(act_fc[k]), e_fc[k]);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int k, input logic b);
    line[k] = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_data(input int k, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) send(k, d[i]);
  endtask

  logic rq [3][$];

  task automatic push_frame(input int k);
    logic [15:0] d;
    int   n1;
    logic pb;
    d = 16'($urandom);
    n1 = 0;
    for (int i = 0; i < $urandom_range(0, 3); i++) rq[k].push_back(1'b1);
    rq[k].push_back(1'b0);
    for (int i = 0; i < cfg_dw[k]; i++) begin
      rq[k].push_back(d[i]);
      n1 += int'(d[i]);
    end
    if (cfg_pm[k] != 0) begin
      pb = (cfg_pm[k] == 1) ? ((n1 % 2) == 0) : ((n1 % 2) == 1);
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      rq[k].push_back(pb);
    end
    for (int s = 0; s < cfg_sb[k]; s++) begin
      if ($urandom_range(0, 7) == 0) begin
        rq[k].push_back(1'b0);
        for (int i = 0; i < $urandom_range(0, 2); i++) rq[k].push_back(1'b0);
        break;
      end
      rq[k].push_back(1'b1);
    end
  endtask

  initial begin
    line[0] = 1'b1;
    line[1] = 1'b1;
    line[2] = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("reset out_byte", 32'(a_out), 32'h0);
    chk("reset busy", 32'(act_busy[0]), 32'h0);
    rst = 1'b0;
    send(0, 1'b1);

    // T1: 0xD2 with correct odd parity
    send(0, 1'b0); send_data(0, 16'hD2, 8); send(0, 1'b1);
    chk("T1 busy before stop", 32'(act_busy[0]), 32'h1);
    send(0, 1'b1);
    chk("T1 done", 32'(act_done[0]), 32'h1);
    chk("T1 out_byte", 32'(a_out), 32'hD2);
    send(0, 1'b1);
    chk("T1 done one cycle", 32'(act_done[0]), 32'h0);

    // T2: same frame, wrong parity
    send(0, 1'b0); send_data(0, 16'hD2, 8); send(0, 1'b0); send(0, 1'b1);
    chk("T2 parity_err", 32'(act_perr[0]), 32'h1);
    chk("T2 done", 32'(act_done[0]), 32'h0);
    chk("T2 out_byte kept", 32'(a_out), 32'hD2);
    send(0, 1'b1);
    chk("T2 parity_err one cycle", 32'(act_perr[0]), 32'h0);

    // T3: framing error, line low 3 cycles, then a good 0x3C frame
    send(0, 1'b0); send_data(0, 16'h5A, 8); send(0, 1'b1); send(0, 1'b0);
    chk("T3 frame_err", 32'(act_ferr[0]), 32'h1);
    send(0, 1'b0);
    chk("T3 frame_err one cycle", 32'(act_ferr[0]), 32'h0);
    send(0, 1'b0);
    send(0, 1'b1);
    chk("T3 idle busy", 32'(act_busy[0]), 32'h0);
    send(0, 1'b0); send_data(0, 16'h3C, 8); send(0, 1'b1); send(0, 1'b1);
    chk("T3 done", 32'(act_done[0]), 32'h1);
    chk("T3 out_byte", 32'(a_out), 32'h3C);

    // T4: back-to-back 0x01 then 0x80, done pulses 11 cycles apart
    send(0, 1'b0); send_data(0, 16'h01, 8); send(0, 1'b0); send(0, 1'b1);
    chk("T4 first done", 32'(act_done[0]), 32'h1);
    chk("T4 first out", 32'(a_out), 32'h01);
    send(0, 1'b0);
    chk("T4 busy on restart", 32'(act_busy[0]), 32'h1);
    send_data(0, 16'h80, 8); send(0, 1'b0);
    send(0, 1'b1);
    chk("T4 second done", 32'(act_done[0]), 32'h1);
    chk("T4 second out", 32'(a_out), 32'h80);
    send(0, 1'b1);

    // T5: DATA_W=7, no parity, two stop bits
    send(1, 1'b0); send_data(1, 16'h41, 7); send(1, 1'b1);
    chk("T5 no done after stop1", 32'(act_done[1]), 32'h0);
    send(1, 1'b1);
    chk("T5 done", 32'(act_done[1]), 32'h1);
    chk("T5 out_byte", 32'(b_out), 32'h41);
    send(1, 1'b0); send_data(1, 16'h41, 7); send(1, 1'b1); send(1, 1'b0);
    chk("T5 frame_err on stop2", 32'(act_ferr[1]), 32'h1);
    send(1, 1'b1);

    // T6: reset mid-DATA, then a normal frame
    send(0, 1'b0); send_data(0, 16'h0F, 4);
    rst = 1'b1;
    send(0, 1'b1);
    rst = 1'b0;
    chk("T6 busy after reset", 32'(act_busy[0]), 32'h0);
    chk("T6 out_byte after reset", 32'(a_out), 32'h0);
    chk("T6 done after reset", 32'(act_done[0]), 32'h0);
    send(0, 1'b1);
    send(0, 1'b0); send_data(0, 16'hA5, 8); send(0, 1'b1); send(0, 1'b1);
    chk("T6 done", 32'(act_done[0]), 32'h1);
    chk("T6 out_byte", 32'(a_out), 32'hA5);

    // even parity on the 16-bit instance: 0x0003 has two ones -> parity 0
    send(2, 1'b0); send_data(2, 16'h0003, 16); send(2, 1'b0); send(2, 1'b1);
    chk("even parity done", 32'(act_done[2]), 32'h1);
    chk("even parity out", 32'(c_out), 32'h0003);
    send(2, 1'b1);

`ifdef SERIAL_RX_ERR_CNT_EN
    for (int i = 0; i < 300; i++) begin
      send(0, 1'b0); send_data(0, 16'hD2, 8); send(0, 1'b0); send(0, 1'b1);
    end
    send(0, 1'b1);
    chk("par_err_cnt saturates", 32'(act_pc[0]), 32'hFF);
`endif

    // randomized traffic on all three instances
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (rq[k].size() == 0) push_frame(k);
        line[k] = rq[k].pop_front();
      end
      rst = ($urandom_range(0, 499) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
